// File: rtl/prog_counter_pkg.sv
// Shared definitions for the programmable counter.
// Contents: wrap-mode encodings used on the mode input of prog_counter.
package prog_counter_pkg;

    localparam logic [1:0] MODE_FREE    = 2'b00;
    localparam logic [1:0] MODE_MODULO  = 2'b01;
    localparam logic [1:0] MODE_SAT     = 2'b10;
    localparam logic [1:0] MODE_ONESHOT = 2'b11;

endpackage

// File: rtl/prog_counter_tick.sv
// Prescaler for prog_counter: produces a one-cycle tick every prescale+1 enabled cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advances the phase counter; en=0 freezes it
//   clr        : restarts the phase (used on counter load); suppresses tick
//   prescale   : divide setting, period = prescale+1 enabled cycles
//   tick       : combinational, high in the enabled cycle that ends a period
module prog_counter_tick #(
    parameter int unsigned PSC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [PSC_W-1:0] prescale,
    output logic             tick
);

    localparam logic [PSC_W-1:0] PSC_ONE = {{(PSC_W-1){1'b0}}, 1'b1};

    logic [PSC_W-1:0] psc_q, psc_d;
    logic             at_end;

    always_comb begin
        at_end = (psc_q == prescale);
        tick   = en && !clr && at_end;
        psc_d  = psc_q;
        if (clr) begin
            psc_d = '0;
        end else if (en) begin
            psc_d = at_end ? '0 : psc_q + PSC_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaler, four wrap modes, terminal-count pulse,
// compare match and replicated output-enable.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable (gates prescaler and counter)
//   load_en    : synchronous load of load_val, highest priority, ignores en
//   load_val   : value loaded into the count
//   up_dn      : 1 = up, 0 = down
//   mode       : FREE / MODULO / SATURATE / ONESHOT
//   limit      : up-direction terminal value (not used in FREE)
//   cmp_val    : compare value for match
//   prescale   : prescaler divide setting
//   oe         : output-enable request
//   count_val  : current count
//   count_oe   : oe replicated across WIDTH
//   tc         : registered one-cycle terminal-count pulse
//   match      : count_val == cmp_val
//   done       : ONESHOT finished flag
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PSC_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] cmp_val,
    input  logic [PSC_W-1:0] prescale,
    input  logic             oe,
    output logic [WIDTH-1:0] count_val,
    output logic [WIDTH-1:0] count_oe,
    output logic             tc,
    output logic             match,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic             tick;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] term;
    logic             wrap;

    prog_counter_tick #(
        .PSC_W (PSC_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (load_en),
        .prescale (prescale),
        .tick     (tick)
    );

    always_comb begin
        step    = up_dn ? count_q + ONE : count_q - ONE;
        term    = up_dn ? limit : '0;
        wrap    = 1'b0;
        count_d = count_q;
        done_d  = done_q;
        tc_d    = 1'b0;
        if (load_en) begin
            count_d = load_val;
            done_d  = 1'b0;
        end else if (tick) begin
            case (mode)
                MODE_FREE: begin
                    // Natural modulo-2^WIDTH roll-over; only the pulse needs detecting.
                    count_d = step;
                    tc_d    = up_dn ? (&count_q) : (count_q == '0);
                end
                MODE_MODULO: begin
                    // >= so a loaded value beyond limit wraps on its first tick.
                    wrap = up_dn ? (count_q >= limit) : (count_q == '0);
                    if (wrap) begin
                        count_d = up_dn ? '0 : limit;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = step;
                    end
                end
                MODE_SAT: begin
                    if (count_q == term) begin
                        tc_d = 1'b1;
                    end else begin
                        count_d = step;
                    end
                end
                MODE_ONESHOT: begin
                    if (!done_q) begin
                        if (count_q == term) begin
                            tc_d   = 1'b1;
                            done_d = 1'b1;
                        end else begin
                            count_d = step;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign count_val = count_q;
    assign count_oe  = {WIDTH{oe}};
    assign tc        = tc_q;
    assign match     = (count_q == cmp_val);
    assign done      = done_q;

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: a driver applies stimulus at the falling edge and
// pushes the expected post-edge state from an arithmetic reference model; a monitor pops
// and compares after every rising edge.
module tb_prog_counter;

    localparam int WIDTH = 8;
    localparam int PSC_W = 4;
    localparam int M     = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0, load_en = 1'b0, up_dn = 1'b1, oe = 1'b0;
    logic [WIDTH-1:0] load_val = '0, limit = '0, cmp_val = '0;
    logic [1:0]       mode = 2'b00;
    logic [PSC_W-1:0] prescale = '0;
    logic [WIDTH-1:0] count_val, count_oe;
    logic             tc, match, done;

    prog_counter #(
        .WIDTH (WIDTH),
        .PSC_W (PSC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load_en   (load_en),
        .load_val  (load_val),
        .up_dn     (up_dn),
        .mode      (mode),
        .limit     (limit),
        .cmp_val   (cmp_val),
        .prescale  (prescale),
        .oe        (oe),
        .count_val (count_val),
        .count_oe  (count_oe),
        .tc        (tc),
        .match     (match),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Pending stimulus; applied at the next falling edge by cycle().
    logic n_en = 0, n_load = 0, n_up = 1, n_oe = 0;
    int   n_lv = 0, n_lim = 0, n_cmp = 0, n_mode = 0, n_psc = 0;

    typedef struct {
        int c;
        bit tc;
        bit done;
        bit match;
        int coe;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state.
    int m_c = 0;
    int m_en_cnt = 0;   // enabled cycles since last load/reset
    bit m_done = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Applies one tick of the wrap rules to the model.
    task automatic model_tick(output bit t);
        int term;
        int step;
        t    = 0;
        term = n_up ? n_lim : 0;
        step = n_up ? (m_c + 1) % M : (m_c + M - 1) % M;
        case (n_mode)
            0: begin
                t   = n_up ? (m_c == M - 1) : (m_c == 0);
                m_c = step;
            end
            1: begin
                if (n_up && m_c >= n_lim) begin
                    m_c = 0; t = 1;
                end else if (!n_up && m_c == 0) begin
                    m_c = n_lim; t = 1;
                end else begin
                    m_c = step;
                end
            end
            2: begin
                if (m_c == term) t = 1;
                else m_c = step;
            end
            default: begin
                if (!m_done) begin
                    if (m_c == term) begin
                        t = 1; m_done = 1;
                    end else begin
                        m_c = step;
                    end
                end
            end
        endcase
    endtask

    task automatic cycle();
        exp_t e;
        bit   t;
        @(negedge clk);
        rst_n    = 1'b1;
        en       = n_en;
        load_en  = n_load;
        load_val = WIDTH'(n_lv);
        up_dn    = n_up;
        oe       = n_oe;
        limit    = WIDTH'(n_lim);
        cmp_val  = WIDTH'(n_cmp);
        mode     = 2'(n_mode);
        prescale = PSC_W'(n_psc);
        t = 0;
        if (n_load) begin
            m_c = n_lv; m_en_cnt = 0; m_done = 0;
        end else if (n_en) begin
            if ((m_en_cnt % (n_psc + 1)) == n_psc) model_tick(t);
            m_en_cnt++;
        end
        e.c = m_c; e.tc = t; e.done = m_done;
        e.match = (m_c == n_cmp);
        e.coe = n_oe ? M - 1 : 0;
        q.push_back(e);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic load(input int v);
        n_load = 1; n_lv = v;
        cycle();
        n_load = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_count", int'(count_val), 0);
        check("reset_tc", int'(tc), 0);
        check("reset_done", int'(done), 0);
        m_c = 0; m_en_cnt = 0; m_done = 0;
    endtask

    // Monitor: every rising edge the DUT presents a new state.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("count_val", int'(count_val), e.c);
            check("tc", int'(tc), int'(e.tc));
            check("done", int'(done), int'(e.done));
            check("match", int'(match), int'(e.match));
            check("count_oe", int'(count_oe), e.coe);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        do_reset();
        // Load/oe
        n_oe = 1; load('hA5); cycles(1);
        n_oe = 0; cycles(1);
        // Reset mid-run
        n_en = 1; load(3); cycles(3);
        do_reset();
        // FREE wrap up and down
        n_mode = 0; n_up = 1; load('hFE); cycles(3);
        n_up = 0; load('h01); cycles(3);
        // Prescaler: period, en gap, load mid-period
        n_up = 1; n_psc = 3; load(0); cycles(9);
        n_en = 0; cycles(2); n_en = 1; cycles(6);
        load('h10); cycles(6);
        n_psc = 0; load(0);
        // MODULO
        n_mode = 1; n_lim = 5; load(0); cycles(8);
        load(9); cycles(2);
        n_up = 0; load(0); cycles(3);
        n_up = 1; n_lim = 0; load(0); cycles(4);
        // SATURATE and ONESHOT
        n_mode = 2; n_lim = 3; load(0); cycles(6);
        n_mode = 3; load(0); cycles(7);
        load(0); cycles(3);
        // Compare, load-vs-tick, FREE->SAT switch at all-ones
        n_mode = 0; n_cmp = 7; load(4); cycles(6);
        n_lim = 'hFF; load('hFE); cycles(1);
        n_mode = 2; cycles(3);
        // Randomised run
        for (int i = 0; i < 1500; i++) begin
            n_en = ($urandom_range(0, 9) < 8);
            n_load = ($urandom_range(0, 19) == 0);
            if (n_load) begin
                n_lv = $urandom_range(0, M - 1);
                n_psc = $urandom_range(0, 2);
            end
            if ($urandom_range(0, 15) == 0) n_mode = $urandom_range(0, 3);
            if ($urandom_range(0, 15) == 0) n_up = $urandom_range(0, 1);
            if ($urandom_range(0, 31) == 0) n_lim = $urandom_range(0, M - 1);
            if ($urandom_range(0, 7) == 0) n_cmp = $urandom_range(0, M - 1);
            n_oe = $urandom_range(0, 1);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle();
            end
        end
        n_load = 0;
        @(posedge clk);
        #3;
        check("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Parametrised successor to the team's 8-bit loadable up-counter with output-enable.
- Adds configurable width, up/down direction and a programmable prescaler.
- Adds four wrap modes (free, modulo, saturate, one-shot), a terminal-count pulse and a compare-match flag.
- Sits in the same TinyTapeout-style datapath, driving user outputs plus a per-bit output-enable vector.

Parameters:
- WIDTH, 8, counter and load/limit/compare width (2..32)
- PSC_W, 4, prescaler setting width; tick period = prescale+1 enabled cycles

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- en  in  1  count enable; gates prescaler and counter
- load_en  in  1  synchronous load of load_val
- load_val  in  WIDTH  value loaded into count
- up_dn  in  1  1 = count up, 0 = count down
- mode  in  2  00 FREE, 01 MODULO, 10 SATURATE, 11 ONESHOT
- limit  in  WIDTH  terminal value for MODULO/SATURATE/ONESHOT in up direction
- cmp_val  in  WIDTH  compare value
- prescale  in  PSC_W  prescaler divide setting
- oe  in  1  output-enable request
- count_val  out  WIDTH  current count
- count_oe  out  WIDTH  replicated oe, combinational
- tc  out  1  registered one-cycle terminal-count pulse
- match  out  1  combinational (count_val == cmp_val)
- done  out  1  ONESHOT finished flag, registered

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset clears count, prescaler counter, tc and done to 0.
- Priority each cycle: load_en > tick > hold.
- Load: count <= load_val; prescaler counter <= 0; done <= 0; tc <= 0. Load acts regardless of en.
- Prescaler: while en=1 and no load, psc increments. When psc == prescale, psc <= 0 and tick=1 that cycle. prescale=0 gives a tick every enabled cycle. en=0 freezes psc.
- Terminal value: up direction is limit (FREE: all-ones); down direction is 0.
- Each tick applies the mode rule for the current up_dn/mode. Inputs are sampled at the tick, so changes mid-run take effect on the next tick.
  - FREE: up all-ones→0, down 0→all-ones; tc pulses on the wrap tick.
  - MODULO: up with count >= limit → 0 (a loaded value beyond limit wraps on its first tick); down with count==0 → limit; tc pulses on the wrap tick.
  - SATURATE: at terminal value, count holds; tc pulses on every tick taken at terminal value.
  - ONESHOT: on the tick with count at terminal value, count holds, done<=1 and tc pulses once. While done=1, ticks are ignored and tc stays 0 until load or reset.
- Otherwise count ±1 modulo 2^WIDTH.
- tc is high exactly one cycle after the qualifying tick edge (registered) and 0 on all non-tick cycles.
- match follows count_val combinationally; it is valid in any mode and with en=0.
- limit=0 in MODULO up: count stays 0, tc pulses every tick.
- Reset asserted mid-count or mid-prescale: immediate clear, no tc pulse.

Decomposition:
- Package prog_counter_pkg: mode localparams MODE_FREE=2'b00, MODE_MODULO=2'b01, MODE_SAT=2'b10, MODE_ONESHOT=2'b11.
- One sub-module: prog_counter_tick (prescaler, params PSC_W; ports clk, rst_n, en, clr, prescale, tick).
- Next-count and tc logic stay in prog_counter.

Test Plan:
- Reset/load/oe: reset, then load 8'hA5, oe=1 → count_val=A5, count_oe=FF; oe=0 → count_oe=00; assert rst_n=0 mid-run → count 0, tc 0, done 0 immediately.
- FREE up wrap: load FE, en=1, prescale=0 → FF, then 00 with tc=1 for exactly one cycle. Down from 01 → 00, then FF with tc pulse.
- Prescaler: prescale=3, en=1 from count 0 → increments every 4th cycle. Toggle en=0 for 2 cycles mid-period → period extends by 2. Load mid-period restarts phase.
- MODULO: limit=5, up from 0 → 0..5,0 with tc on the 5→0 tick. Load 9 → next tick 0. Down from 0 → 5 with tc. limit=0 → tc every tick.
- SATURATE/ONESHOT: SATURATE limit=3 up → holds 3, tc each tick at 3. ONESHOT limit=3 → stops at 3, done=1, single tc, further ticks no tc; load 0 → done=0, resumes.
- Compare and simultaneous events: cmp_val=07 → match high only while count=07. load_en and tick in the same cycle → load wins, no tc. Mode switch FREE→SAT at count FF → holds at limit behaviour next tick.
